// File: rtl/pc_sequencer_if.sv
// Fetch-side signal bundle for pc_sequencer: control inputs from decode/branch resolve,
// fetch address and status outputs toward instruction memory.
interface pc_sequencer_if #(
    parameter int unsigned N    = 10,
    parameter int unsigned OFFW = 6
);
    logic            stall;
    logic            imem_ack;
    logic            branch_req;
    logic            branch_taken;
    logic [OFFW-1:0] branch_offset;
    logic            jump_req;
    logic [N-1:0]    jump_addr;
    logic [N-1:0]    pc;
    logic [N-1:0]    pc_plus1;
    logic            imem_req;
    logic            flush;
    logic [1:0]      seq_state;

    modport master (
        input  stall, imem_ack, branch_req, branch_taken, branch_offset, jump_req, jump_addr,
        output pc, pc_plus1, imem_req, flush, seq_state
    );

    modport slave (
        output stall, imem_ack, branch_req, branch_taken, branch_offset, jump_req, jump_addr,
        input  pc, pc_plus1, imem_req, flush, seq_state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, issues fetch requests and inserts a single
// flush bubble after every jump or taken branch.
module pc_sequencer #(
    parameter int unsigned   N        = 10,
    parameter int unsigned   OFFW     = 6,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input logic               clk,
    input logic               rst,
    pc_sequencer_if.master    bus
);
    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StFlush = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic         imem_req_q, imem_req_d;
    logic         flush_q, flush_d;

    logic         accept;
    logic [N-1:0] pc_plus1;
    logic [N-1:0] offset_ext;
    logic [N-1:0] branch_target;

    assign pc_plus1      = pc_q + N'(1);
    assign offset_ext    = {{(N - OFFW){bus.branch_offset[OFFW-1]}}, bus.branch_offset};
    assign branch_target = pc_plus1 + offset_ext;
    assign accept        = (state_q == StFetch) && bus.imem_ack && !bus.stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (accept) begin
                    // Jump outranks a taken branch; branch_taken alone is meaningless.
                    if (bus.jump_req) begin
                        pc_d    = bus.jump_addr;
                        state_d = StFlush;
                    end else if (bus.branch_req && bus.branch_taken) begin
                        pc_d    = branch_target;
                        state_d = StFlush;
                    end else begin
                        pc_d    = pc_plus1;
                    end
                end
            end
            StFlush: begin
                state_d = StFetch;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
        imem_req_d = (state_d == StFetch);
        flush_d    = (state_d == StFlush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            imem_req_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            imem_req_q <= imem_req_d;
            flush_q    <= flush_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus1  = pc_plus1;
    assign bus.imem_req  = imem_req_q;
    assign bus.flush     = flush_q;
    assign bus.seq_state = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a cycle-level reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_pc_sequencer;
    localparam int N    = 10;
    localparam int OFFW = 6;
    localparam int MOD  = 1 << N;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   cmp_en;

    pc_sequencer_if #(.N(N), .OFFW(OFFW)) bus ();

    pc_sequencer #(.N(N), .OFFW(OFFW), .RESET_PC('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = boot, 1 = fetching, 2 = bubble after redirect.
    int m_pc;
    int m_phase;

    function automatic int wrap(input int v);
        return ((v % MOD) + MOD) % MOD;
    endfunction

    always @(posedge clk) begin
        int off;
        if (rst) begin
            m_pc    = 0;
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 2) begin
            m_phase = 1;
        end else if (bus.imem_ack && !bus.stall) begin
            off = int'(bus.branch_offset);
            if (off >= (1 << (OFFW - 1))) off = off - (1 << OFFW);
            if (bus.jump_req) begin
                m_pc    = int'(bus.jump_addr);
                m_phase = 2;
            end else if (bus.branch_req && bus.branch_taken) begin
                m_pc    = wrap(m_pc + 1 + off);
                m_phase = 2;
            end else begin
                m_pc    = wrap(m_pc + 1);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_pc", 32'(bus.pc), m_pc);
            check("model_pc_plus1", 32'(bus.pc_plus1), wrap(m_pc + 1));
            check("model_imem_req", 32'(bus.imem_req), (m_phase == 1) ? 1 : 0);
            check("model_flush", 32'(bus.flush), (m_phase == 2) ? 1 : 0);
            check("model_state", 32'(bus.seq_state), m_phase);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int pc, input int req, input int fl,
                              input int st);
        check({tag, "_pc"}, 32'(bus.pc), pc);
        check({tag, "_req"}, 32'(bus.imem_req), req);
        check({tag, "_flush"}, 32'(bus.flush), fl);
        check({tag, "_state"}, 32'(bus.seq_state), st);
    endtask

    task automatic clear_ctl();
        bus.branch_req    = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = '0;
        bus.jump_req      = 1'b0;
        bus.jump_addr     = '0;
    endtask

    task automatic jump_to(input int addr);
        bus.imem_ack  = 1'b1;
        bus.stall     = 1'b0;
        bus.jump_req  = 1'b1;
        bus.jump_addr = N'(addr);
        cyc();
        clear_ctl();
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        rst    = 1'b1;
        bus.stall    = 1'b0;
        bus.imem_ack = 1'b0;
        clear_ctl();

        // Reset and boot; stall must not hold the sequencer in BOOT.
        cyc();
        cyc();
        expect_out("reset", 0, 0, 0, 0);
        check("reset_pc_plus1", 32'(bus.pc_plus1), 1);
        cmp_en    = 1'b1;
        rst       = 1'b0;
        bus.stall = 1'b1;
        cyc();
        expect_out("boot_exit", 0, 1, 0, 1);
        bus.stall = 1'b0;

        // Sequential fetch 1..5
        bus.imem_ack = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            expect_out("seq", i, 1, 0, 1);
        end

        // Backward branch at 5 by -3 lands on 3
        bus.branch_req    = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 6'b111101;
        cyc();
        expect_out("bwd_branch", 3, 0, 1, 2);
        clear_ctl();
        cyc();
        expect_out("bwd_resume", 3, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc();
        check("walk_to_7", 32'(bus.pc), 7);

        // Not-taken branch at 7
        bus.branch_req    = 1'b1;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 6'b010101;
        cyc();
        expect_out("not_taken", 8, 1, 0, 1);
        clear_ctl();

        // Jump beats a taken branch; jump during FLUSH is ignored
        bus.jump_req      = 1'b1;
        bus.jump_addr     = 10'h200;
        bus.branch_req    = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 6'd5;
        cyc();
        expect_out("jump_prio", 512, 0, 1, 2);
        bus.jump_addr = 10'h100;
        cyc();
        expect_out("jump_in_flush", 512, 1, 0, 1);
        clear_ctl();

        // Stall at 9 for 3 cycles, with a jump presented that must not be sampled
        jump_to(9);
        check("at_9", 32'(bus.pc), 9);
        bus.stall     = 1'b1;
        bus.jump_req  = 1'b1;
        bus.jump_addr = 10'd55;
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_out("stall", 9, 1, 0, 1);
        end
        clear_ctl();
        bus.stall = 1'b0;
        cyc();
        expect_out("stall_release", 10, 1, 0, 1);

        // No ack: PC holds
        bus.imem_ack = 1'b0;
        cyc();
        expect_out("no_ack", 10, 1, 0, 1);

        // Sequential wrap 1023 -> 0
        jump_to(1023);
        cyc();
        expect_out("seq_wrap", 0, 1, 0, 1);

        // Branch wrap: 1020 + 1 + 31 = 28 mod 1024
        jump_to(1020);
        bus.branch_req    = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 6'b011111;
        cyc();
        expect_out("branch_wrap", 28, 0, 1, 2);
        clear_ctl();
        cyc();
        expect_out("branch_wrap_resume", 28, 1, 0, 1);

        // Reset during FLUSH overrides everything
        bus.jump_req  = 1'b1;
        bus.jump_addr = 10'd100;
        cyc();
        expect_out("pre_reset_flush", 100, 0, 1, 2);
        rst = 1'b1;
        cyc();
        expect_out("reset_in_flush", 0, 0, 0, 0);
        clear_ctl();
        rst = 1'b0;
        cyc();
        expect_out("reboot", 0, 1, 0, 1);
        cyc();
        expect_out("reboot_seq", 1, 1, 0, 1);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle CPU front end. It owns the PC register, issues instruction-fetch requests, and decides each cycle whether the next PC is sequential, a branch target, or a jump target. It computes the branch target internally as PC+1 plus the sign-extended 6-bit offset. After every redirect it inserts a one-cycle flush bubble. It sits between the decode/branch-resolve logic and the instruction memory.

## Interface
- N, 10, PC and address width
- OFFW, 6, branch offset width (two's complement)
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset; synchronous and active-high
- stall  in  1  downstream hazard stall; freezes PC advance
- imem_ack  in  1  instruction memory has returned the word for `pc` this cycle
- branch_req  in  1  the instruction at `pc` is a conditional branch
- branch_taken  in  1  branch condition true; qualified by branch_req
- branch_offset  in  OFFW  signed word offset relative to PC+1
- jump_req  in  1  the instruction at `pc` is an unconditional jump
- jump_addr  in  N  absolute jump target
- pc  out  N  current fetch address (registered)
- pc_plus1  out  N  pc+1 mod 2^N (combinational from `pc`)
- imem_req  out  1  fetch request for `pc` (registered)
- flush  out  1  squash the instruction currently in decode (registered)
- seq_state  out  2  FSM state for debug: BOOT=0, FETCH=1, FLUSH=2

## Operation
- FSM states:
  - BOOT: `imem_req`=0, `flush`=0, `pc` holds; unconditionally goes to FETCH next cycle.
  - FETCH: `imem_req`=1. A cycle is *accepted* when `imem_ack`=1 and `stall`=0.
    - Not accepted: `pc` holds, `imem_req` stays 1, state stays FETCH.
    - Accepted: `pc` loads the next PC, selected by priority below.
      - If the next PC is a redirect, go to FLUSH.
      - Otherwise stay in FETCH.
  - FLUSH: `flush`=1, `imem_req`=0, `pc` holds the redirect target; goes to FETCH next cycle.
- Next-PC priority on an accepted cycle:
  1. `jump_req` → `jump_addr`
  2. `branch_req & branch_taken` → branch target
  3. otherwise → `pc_plus1`
- `branch_taken` without `branch_req` is ignored.
- Branch target = `pc_plus1` + sign-extend(`branch_offset` to N). The offset is not shifted: word addressing.
- All PC arithmetic is modulo 2^N. Wrap-around is silent; there is no overflow flag.
- `branch_req`, `jump_req`, `branch_offset` and `jump_addr` are sampled only on accepted FETCH cycles. They are don't-care in BOOT, in FLUSH, and on non-accepted cycles.
- `imem_ack` is ignored outside FETCH.
- `stall` has no effect in BOOT or FLUSH: those states always advance.
- Reset:
  - `rst`=1 at any edge, in any state, forces `pc`=RESET_PC, `imem_req`=0, `flush`=0, state BOOT.
  - Reset overrides every other input in the same cycle, including a pending redirect.

## Timing
- Reset values: `pc`=RESET_PC, `pc_plus1`=RESET_PC+1, `imem_req`=0, `flush`=0, `seq_state`=0.
- Reset release: if the first edge with `rst`=0 is T, then `imem_req`=1 from T+1.
- Sequential accept at edge T: new `pc` visible after T. Throughput is one instruction per cycle with `imem_ack` held high.
- Redirect accepted at edge T:
  - after T: `pc`=target, `flush`=1, `imem_req`=0;
  - after T+1: `flush`=0, `imem_req`=1.
  - Penalty is exactly one bubble.
- Back-to-back redirects: a redirect can only be accepted once per FETCH visit, so the minimum spacing between redirects is 2 cycles.
- All outputs except `pc_plus1` are registered; there is no combinational input-to-output path.

## Test plan
- Reset and boot: hold `rst`=1 for 2 cycles, then release → `pc`=0, `flush`=0, `imem_req`=0 in the first cycle after release, `imem_req`=1 in the next.
- Sequential fetch: `imem_ack`=1 continuously from `pc`=0 → `pc` goes 1, 2, 3, 4 on consecutive cycles; `flush` never asserts.
- Backward branch: at `pc`=5 drive `branch_req`=1, `branch_taken`=1, `branch_offset`=6'b111101 (-3), ack → `pc`=3, `flush`=1 for exactly one cycle with `imem_req`=0, then FETCH resumes at 3.
- Wrap and not-taken:
  - `pc`=1023, sequential ack → `pc`=0.
  - `pc`=1020, offset +31, taken → `pc`=28.
  - `branch_req`=1 with `branch_taken`=0 at `pc`=7 → `pc`=8 with no flush.
- Priority and sampling:
  - `jump_req`=1 with `jump_addr`=0x200 and a taken branch in the same accepted cycle → `pc`=512.
  - `jump_req` asserted during FLUSH is ignored.
- Stall and mid-operation reset:
  - `stall`=1 with `imem_ack`=1 for 3 cycles at `pc`=9 → `pc` stays 9 and `imem_req` stays 1; on release, the next accepted cycle gives `pc`=10.
  - `rst`=1 during FLUSH → `pc`=0, state BOOT, `flush`=0.
